// File: rtl/fighter_pose_sequencer.sv
// Per-player pose FSM (stand/crouch/punch/kick/stun) advanced on frame ticks, plus the
// registered 64x64 sprite ROM address generator with horizontal mirroring.
module fighter_pose_sequencer #(
  parameter int unsigned SPRITE_W      = 64,
  parameter int unsigned SPRITE_H      = 64,
  parameter int unsigned ADDR_W        = 12,
  parameter int unsigned PUNCH_FRAMES  = 12,
  parameter int unsigned KICK_FRAMES   = 16,
  parameter int unsigned ACTIVE_FRAMES = 4,
  parameter int unsigned STUN_FRAMES   = 20
) (
  input  logic              vga_clk,
  input  logic              reset_n,
  input  logic              frame_tick,
  input  logic              btn_crouch,
  input  logic              btn_punch,
  input  logic              btn_kick,
  input  logic              hit,
  input  logic              facing_left,
  input  logic [9:0]        sprite_x,
  input  logic [9:0]        sprite_y,
  input  logic [9:0]        DrawX,
  input  logic [9:0]        DrawY,
  output logic [2:0]        pose,
  output logic [ADDR_W-1:0] rom_address,
  output logic              in_sprite,
  output logic              attack_active,
  output logic              busy
);

  localparam int unsigned XW = $clog2(SPRITE_W);

  typedef enum logic [2:0] {
    StStand  = 3'd0,
    StCrouch = 3'd1,
    StPunch  = 3'd2,
    StKick   = 3'd3,
    StStun   = 3'd4
  } state_e;

  state_e            state_q, state_d;
  logic [5:0]        cnt_q, cnt_d;
  logic              hit_pending_q, hit_pending_d;
  logic              attack_q, attack_d;
  logic              busy_q, busy_d;
  logic [9:0]        x_q, y_q;
  logic              facing_q;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              in_q, in_d;
  logic [10:0]       rel_x, rel_y;
  logic [XW-1:0]     col;

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    hit_pending_d = hit_pending_q;
    if (frame_tick) begin
      hit_pending_d = 1'b0;
      if (hit_pending_q || hit) begin
        state_d = StStun;
        cnt_d   = 6'(STUN_FRAMES - 1);
      end else if (busy_q) begin
        // Counter reaching zero ends the action; no new attack may start on this tick.
        if (cnt_q != 6'd0) begin
          cnt_d = cnt_q - 6'd1;
        end else begin
          state_d = btn_crouch ? StCrouch : StStand;
        end
      end else if (btn_punch) begin
        state_d = StPunch;
        cnt_d   = 6'(PUNCH_FRAMES - 1);
      end else if (btn_kick) begin
        state_d = StKick;
        cnt_d   = 6'(KICK_FRAMES - 1);
      end else begin
        state_d = btn_crouch ? StCrouch : StStand;
      end
    end else if (hit) begin
      hit_pending_d = 1'b1;
    end
    attack_d = ((state_d == StPunch) || (state_d == StKick)) && (cnt_d < 6'(ACTIVE_FRAMES));
    busy_d   = (state_d == StPunch) || (state_d == StKick) || (state_d == StStun);
  end

  // Address path uses the position latched at the last frame tick, not the live inputs.
  always_comb begin
    rel_x  = {1'b0, DrawX} - {1'b0, x_q};
    rel_y  = {1'b0, DrawY} - {1'b0, y_q};
    in_d   = !rel_x[10] && (rel_x < 11'(SPRITE_W)) && !rel_y[10] && (rel_y < 11'(SPRITE_H));
    col    = facing_q ? ~rel_x[XW-1:0] : rel_x[XW-1:0];
    addr_d = in_d ? ((ADDR_W'(rel_y) << XW) + ADDR_W'(col)) : '0;
  end

  always_ff @(posedge vga_clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= StStand;
      cnt_q         <= 6'd0;
      hit_pending_q <= 1'b0;
      attack_q      <= 1'b0;
      busy_q        <= 1'b0;
      x_q           <= 10'd0;
      y_q           <= 10'd0;
      facing_q      <= 1'b0;
      addr_q        <= '0;
      in_q          <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      hit_pending_q <= hit_pending_d;
      attack_q      <= attack_d;
      busy_q        <= busy_d;
      addr_q        <= addr_d;
      in_q          <= in_d;
      if (frame_tick) begin
        x_q      <= sprite_x;
        y_q      <= sprite_y;
        facing_q <= facing_left;
      end
    end
  end

  assign pose          = state_q;
  assign rom_address   = addr_q;
  assign in_sprite     = in_q;
  assign attack_active = attack_q;
  assign busy          = busy_q;

endmodule

// File: tb/tb_fighter_pose_sequencer.sv
// Self-checking bench: directed pose/address scenarios plus randomized traffic compared every
// cycle against a frame-level behavioural model.
module tb_fighter_pose_sequencer;

  localparam int SW = 64, SH = 64, AW = 12;
  localparam int PUNCH = 12, KICK = 16, ACTIVE = 4, STUN = 20;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          frame_tick = 0, btn_crouch = 0, btn_punch = 0, btn_kick = 0, hit = 0;
  logic          facing_left = 0;
  logic [9:0]    sprite_x = 0, sprite_y = 0, DrawX = 0, DrawY = 0;
  logic [2:0]    pose;
  logic [AW-1:0] rom_address;
  logic          in_sprite, attack_active, busy;

  int checks = 0;
  int failures = 0;

  fighter_pose_sequencer dut (
    .vga_clk      (clk),
    .reset_n      (reset_n),
    .frame_tick   (frame_tick),
    .btn_crouch   (btn_crouch),
    .btn_punch    (btn_punch),
    .btn_kick     (btn_kick),
    .hit          (hit),
    .facing_left  (facing_left),
    .sprite_x     (sprite_x),
    .sprite_y     (sprite_y),
    .DrawX        (DrawX),
    .DrawY        (DrawY),
    .pose         (pose),
    .rom_address  (rom_address),
    .in_sprite    (in_sprite),
    .attack_active(attack_active),
    .busy         (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: pose plus frames remaining in the current action (left counts the
  // current frame, so an attack of N frames starts with left = N).
  int m_pose = 0, m_left = 0, m_x = 0, m_y = 0, m_addr = 0;
  bit m_face = 0, m_pend = 0, m_in = 0, m_act = 0;

  always @(posedge clk or negedge reset_n) begin
    int rx, ry;
    bit evt, was_busy;
    if (!reset_n) begin
      m_pose = 0; m_left = 0; m_x = 0; m_y = 0; m_face = 0;
      m_pend = 0; m_in = 0; m_act = 0; m_addr = 0;
    end else begin
      rx = int'(DrawX) - m_x;
      ry = int'(DrawY) - m_y;
      m_in = (rx >= 0) && (rx < SW) && (ry >= 0) && (ry < SH);
      m_addr = m_in ? ((ry * SW + (m_face ? (SW - 1 - rx) : rx)) % (1 << AW)) : 0;
      if (frame_tick) begin
        evt = m_pend || hit;
        m_pend = 0;
        m_x = int'(sprite_x); m_y = int'(sprite_y); m_face = facing_left;
        was_busy = (m_pose >= 2);
        if (evt) begin
          m_pose = 4; m_left = STUN;
        end else if (was_busy && m_left > 1) begin
          m_left--;
        end else if (was_busy) begin
          m_pose = btn_crouch ? 1 : 0; m_left = 0;
        end else if (btn_punch) begin
          m_pose = 2; m_left = PUNCH;
        end else if (btn_kick) begin
          m_pose = 3; m_left = KICK;
        end else begin
          m_pose = btn_crouch ? 1 : 0;
        end
        m_act = (m_pose == 2 || m_pose == 3) && (m_left <= ACTIVE);
      end else if (hit) begin
        m_pend = 1;
      end
    end
  end

  always @(negedge clk) begin
    chk("pose", 32'(pose), 32'(m_pose));
    chk("busy", 32'(busy), 32'(m_pose >= 2));
    chk("attack_active", 32'(attack_active), 32'(m_act));
    chk("in_sprite", 32'(in_sprite), 32'(m_in));
    chk("rom_address", 32'(rom_address), 32'(m_addr));
  end

  // Called at a falling edge; returns at the falling edge after the tick has been applied.
  task automatic do_tick();
    frame_tick = 1;
    @(negedge clk);
    frame_tick = 0;
    @(negedge clk);
  endtask

  initial begin
    int n, mask, phase;
    repeat (3) @(negedge clk);
    reset_n = 1;
    @(negedge clk);
    chk("reset_pose", 32'(pose), 0);
    chk("reset_busy", 32'(busy), 0);
    chk("reset_addr", 32'(rom_address), 0);

    // Punch: 12 frames, hitbox on the last 4.
    btn_punch = 1;
    do_tick();
    btn_punch = 0;
    n = 0; mask = 0;
    while (pose == 3'd2 && n < 40) begin
      n++;
      if (attack_active) mask |= (1 << n);
      do_tick();
    end
    chk("punch_len", 32'(n), 12);
    chk("punch_active_mask", 32'(mask), 32'h1E00);
    chk("punch_end_pose", 32'(pose), 0);

    // Kick interrupted by a hit 100 cycles before the tick ending frame 3; stun restarted at 10.
    btn_kick = 1;
    do_tick();
    btn_kick = 0;
    do_tick();
    do_tick();
    chk("kick_pose", 32'(pose), 3);
    hit = 1;
    @(negedge clk);
    hit = 0;
    repeat (99) @(negedge clk);
    do_tick();
    chk("stun_entry", 32'(pose), 4);
    n = 1;
    for (int i = 0; i < 40; i++) begin
      if (n == 10) begin
        hit = 1;
        @(negedge clk);
        hit = 0;
        repeat (5) @(negedge clk);
      end
      do_tick();
      if (pose == 3'd4) n++;
      else break;
    end
    chk("stun_total", 32'(n), 30);

    // Hit coincident with the tick beats a punch request and is consumed by that tick.
    btn_punch = 1; hit = 1; frame_tick = 1;
    @(negedge clk);
    hit = 0; frame_tick = 0; btn_punch = 0;
    @(negedge clk);
    chk("coinc_pose", 32'(pose), 4);
    repeat (19) do_tick();
    chk("coinc_still_stun", 32'(pose), 4);
    do_tick();
    chk("coinc_end", 32'(pose), 0);

    // Address generation.
    sprite_x = 100; sprite_y = 50; facing_left = 0;
    do_tick();
    DrawX = 163; DrawY = 51;
    @(negedge clk);
    chk("addr_in", 32'(in_sprite), 1);
    chk("addr_127", 32'(rom_address), 127);
    DrawX = 164;
    @(negedge clk);
    chk("addr_right_out", 32'(in_sprite), 0);
    chk("addr_right_zero", 32'(rom_address), 0);
    facing_left = 1;
    do_tick();
    DrawX = 100; DrawY = 50;
    @(negedge clk);
    chk("addr_mirror", 32'(rom_address), 63);
    sprite_x = 0;
    @(negedge clk);
    chk("addr_hold", 32'(rom_address), 63);
    do_tick();
    @(negedge clk);
    chk("addr_new_frame", 32'(in_sprite), 0);

    // Asynchronous reset in kick frame 5.
    btn_kick = 1;
    do_tick();
    btn_kick = 0;
    repeat (4) do_tick();
    #2 reset_n = 0;
    #1;
    chk("async_pose", 32'(pose), 0);
    chk("async_attack", 32'(attack_active), 0);
    chk("async_busy", 32'(busy), 0);
    @(negedge clk);
    reset_n = 1;

    // Randomized traffic checked by the model every cycle.
    phase = 5;
    for (int i = 0; i < 8000; i++) begin
      @(negedge clk);
      frame_tick = (phase == 0);
      phase = (phase == 0) ? int'($urandom_range(6, 20)) : phase - 1;
      hit = ($urandom_range(0, 39) == 0);
      if ($urandom_range(0, 15) == 0) begin
        btn_punch  = ($urandom_range(0, 3) == 0);
        btn_kick   = ($urandom_range(0, 3) == 0);
        btn_crouch = $urandom_range(0, 1) == 1;
      end
      if ($urandom_range(0, 99) == 0) begin
        sprite_x    = 10'($urandom_range(0, 1023));
        sprite_y    = 10'($urandom_range(0, 1023));
        facing_left = $urandom_range(0, 1) == 1;
      end
      DrawX = 10'(int'(sprite_x) + int'($urandom_range(0, 80)) - 8);
      DrawY = 10'(int'(sprite_y) + int'($urandom_range(0, 80)) - 8);
      if ($urandom_range(0, 1999) == 0) begin
        #2 reset_n = 0;
        @(negedge clk);
        reset_n = 1;
      end
    end
    @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/fighter_pose_sequencer.md
Name: fighter_pose_sequencer

Overview:
- Per-player pose controller that decides which fighter sprite ROM (stand/crouch/punch/kick/stun) is shown each frame.
- Generates the shared 64x64 sprite ROM address for the current pixel, including horizontal mirroring.
- Sits between player input/collision logic and the sprite ROM + palette datapath; its pose output drives the ROM select mux.
- Pose and position change only at frame boundaries, so no tearing.

Parameters:
- SPRITE_W, 64, sprite width in pixels (power of 2)
- SPRITE_H, 64, sprite height in pixels
- ADDR_W, 12, ROM address width; must satisfy 2^ADDR_W >= SPRITE_W*SPRITE_H
- PUNCH_FRAMES, 12, punch duration in frames (1..63)
- KICK_FRAMES, 16, kick duration in frames (1..63)
- ACTIVE_FRAMES, 4, number of final attack frames with attack_active high (<= min attack length)
- STUN_FRAMES, 20, hit-stun duration in frames (1..63)

Ports:
- vga_clk  in  1  pixel clock; all state on posedge
- reset_n  in  1  asynchronous active-low reset
- frame_tick  in  1  one-cycle pulse per frame at start of vertical blank
- btn_crouch  in  1  level, crouch held
- btn_punch  in  1  level, punch request
- btn_kick  in  1  level, kick request
- hit  in  1  one-cycle pulse from collision logic, any cycle
- facing_left  in  1  1 = mirror sprite horizontally
- sprite_x  in  10  sprite top-left X
- sprite_y  in  10  sprite top-left Y
- DrawX  in  10  current pixel X
- DrawY  in  10  current pixel Y
- pose  out  3  0 STAND, 1 CROUCH, 2 PUNCH, 3 KICK, 4 STUN
- rom_address  out  ADDR_W  sprite ROM address
- in_sprite  out  1  current pixel lies inside sprite box
- attack_active  out  1  hitbox live
- busy  out  1  in PUNCH, KICK or STUN

Behaviour:
- Reset (async, reset_n low):
  - state = STAND, frame counter = 0, hit_pending = 0.
  - Latched x/y/facing = 0.
  - pose = 0, rom_address = 0, in_sprite = 0, attack_active = 0, busy = 0.
  - Reset mid-attack or mid-stun aborts immediately to STAND.
- hit_pending:
  - Set on any cycle with hit = 1.
  - Cleared on frame_tick; hit arriving on the same cycle as frame_tick is consumed by that tick.
- State machine: updates only on cycles with frame_tick = 1; otherwise holds.
- Priority at each tick:
  1. (hit_pending or hit) -> STUN, counter = STUN_FRAMES-1. Also applies if already in STUN (restarts the stun).
  2. In PUNCH/KICK/STUN with counter != 0 -> stay, counter decrements.
  3. In PUNCH/KICK/STUN with counter == 0 -> CROUCH if btn_crouch, else STAND. No attack start on this tick.
  4. From STAND/CROUCH: btn_punch -> PUNCH, counter = PUNCH_FRAMES-1.
  5. Else btn_kick -> KICK, counter = KICK_FRAMES-1.
  6. Else btn_crouch -> CROUCH.
  7. Else STAND.
- Attack timing: an attack spans exactly PUNCH_FRAMES/KICK_FRAMES frames, and stun exactly STUN_FRAMES, each counted from the entry tick. Attacks are interruptible only by hit.
- pose: registered and equal to state encoding.
- busy: 1 in PUNCH, KICK or STUN.
- attack_active: 1 when state is PUNCH or KICK and counter < ACTIVE_FRAMES; registered with the state.
- sprite_x, sprite_y, facing_left: latched on frame_tick and used for address generation during the following frame.
- Address generation (latency 1 vga_clk, registered):
  - rel_x = DrawX - x_q and rel_y = DrawY - y_q, evaluated as 11-bit signed.
  - in_sprite = 1 when 0 <= rel_x < SPRITE_W and 0 <= rel_y < SPRITE_H.
  - col = facing_q ? SPRITE_W-1-rel_x : rel_x.
  - rom_address = rel_y*SPRITE_W + col, truncated to ADDR_W bits. Use shift, no divider.
  - rom_address = 0 whenever in_sprite = 0.
- Boundaries:
  - Sprite partially off right/bottom edge: only on-screen pixels flagged, no wrap.
  - x_q > DrawX yields negative rel_x, so in_sprite = 0.

Test Plan:
- Release reset with all inputs 0 -> pose=0, busy=0, rom_address=0. Assert reset_n low mid-KICK (frame 5) -> pose=0 and attack_active=0 within the same cycle (async).
- btn_punch held one tick, then released -> pose=2 for exactly 12 ticks; attack_active high on ticks 9-12 only; returns to pose 0 on tick 13.
- hit pulse 100 cycles before a tick during KICK frame 3 -> pose=4 on next tick for 20 ticks. Second hit at stun frame 10 -> stun restarts, total stun 30 ticks.
- hit coincident with frame_tick while btn_punch=1 -> pose=4; hit_pending=0 afterward; punch is not started.
- sprite_x=100, sprite_y=50, facing_left=0 latched; DrawX=163, DrawY=51 -> one cycle later in_sprite=1, rom_address=127. DrawX=164 -> in_sprite=0, rom_address=0.
- Same position with facing_left=1; DrawX=100, DrawY=50 -> rom_address=63. Change sprite_x mid-frame -> no address change until the next frame_tick.
